mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates one unified single-port synchronous memory between the instruction-fetch requester and the data (load/store) requester of the 5-stage RISC-V pipeline. It issues at most one memory access per cycle, routes the one-cycle-latency read data back to the owner, and guarantees fetch forward progress with a starvation counter. A denied grant is the requester's stall condition and feeds the hazard unit as an extra stall source.

## Interface
- AW, 32, address width (byte address)
- DW, 32, data width; byte-enable width is DW/8
- STARVE_MAX, 4, consecutive contended cycles fetch may lose before it is forced to win (range 1..15)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- i_req  in  1  fetch read request
- i_addr  in  AW  fetch address
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch read data valid
- i_rdata  out  DW  fetch read data
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_be  in  DW/8  store byte enables
- d_addr  in  AW  data address
- d_wdata  in  DW  store data, already lane-aligned
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  DW  load data
- m_req  out  1  memory access strobe
- m_we  out  1  memory write enable
- m_be  out  DW/8  memory byte enables
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_rdata  in  DW  memory read data, valid the cycle after a read strobe

## Operation
- Grant is combinational from the requests and the registered arbitration state; at most one of i_gnt/d_gnt is high per cycle; a grant is only ever given to an asserted request.
- Single requester: granted the same cycle.
- Contention (both requesting), baseline policy: data wins, unless starve_cnt == STARVE_MAX, in which case fetch wins.
- starve_cnt (4 bits): increments when i_req && !i_gnt; clears when i_gnt or !i_req; saturates at STARVE_MAX.
- Memory side mirrors the granted request: fetch drives m_we=0, m_be=all ones; data passes d_we/d_be/d_addr/d_wdata. No grant -> m_req=0, m_we=0, m_be=0, m_addr/m_wdata=0.
- Owner register (2 bits: NONE, INSTR, DATA) records the granted read; a store records NONE.
- Response cycle: owner INSTR -> i_rvalid=1, i_rdata=m_rdata; owner DATA -> d_rvalid=1, d_rdata=m_rdata. The inactive side's rdata is 0.
- Stores complete at grant; no d_rvalid for stores.
- Requesters hold req/address stable until granted; the arbiter does not latch ungranted requests.

## Timing
- Reset values: owner=NONE, starve_cnt=0, rr pointer=DATA, all rvalid=0; grant/memory outputs follow the combinational rule (0 when no request).
- Read latency: grant in cycle N, rvalid and rdata in cycle N+1. Back-to-back grants every cycle; throughput one access/cycle.
- Grant in N and response of the previous read in N coexist (pipelined).
- Reset asserted mid-access: owner clears immediately, the pending response is dropped (no rvalid after reset), starve_cnt clears.
- Request dropped while not granted: no state change except starve_cnt clearing.

## Configuration
- MEM_PORT_ARB_RR_EN defined: contention resolved round-robin; 1-bit pointer holds the last winner, the other requester wins; pointer updates on every grant. The starvation counter remains but can never reach STARVE_MAX>=2.
- Not defined: fixed data priority with starvation override as described above; no pointer flop.

## Structure
- Shared package: owner encoding constants (OWN_NONE=0, OWN_INSTR=1, OWN_DATA=2) and the default STARVE_MAX.
- One sub-module natural: mem_port_starve_cnt (saturating counter with clear, outputs at-limit flag).

## Test plan
- Fetch only, i_addr=0x00000010 for 3 cycles -> i_gnt=1 each cycle, m_addr follows, i_rvalid one cycle later with m_rdata each cycle.
- Contention, load d_addr=0x100 vs fetch 0x20, baseline -> d_gnt=1, i_gnt=0, next cycle d_rvalid=1, d_rdata=m_rdata, i_rvalid=0.
- Sustained contention, STARVE_MAX=4, baseline -> data wins cycles 0-3, fetch wins cycle 4, counter returns to 0, data wins cycle 5.
- Store d_we=1, d_be=0b0100, d_wdata=0x00AB0000 alone -> m_we=1, m_be=0b0100, m_wdata=0x00AB0000, no d_rvalid next cycle.
- rst pulsed the cycle after a fetch grant -> i_rvalid stays 0, owner=NONE, starve_cnt=0.
- With MEM_PORT_ARB_RR_EN, continuous contention for 6 cycles -> grants alternate I,D,I,D,I,D starting with fetch after reset.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter: response-owner
// encoding, default starvation limit and the owner-update helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  localparam int STARVE_MAX_DEF = 4;

  // A store completes at grant, so only a granted read claims next cycle's response.
  function automatic owner_e next_owner(input logic i_gnt, input logic d_gnt, input logic d_we);
    owner_e own;
    if (i_gnt) begin
      own = OWN_INSTR;
    end else if (d_gnt && !d_we) begin
      own = OWN_DATA;
    end else begin
      own = OWN_NONE;
    end
    return own;
  endfunction

endpackage

// File: rtl/mem_port_starve_cnt.sv
// Saturating fetch-starvation counter with clear; flags when fetch must win.
module mem_port_starve_cnt
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [3:0] LIMIT = 4'(STARVE_MAX);

  logic [3:0] cnt_r;

  // Count consecutive lost contention cycles, holding at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= 4'd0;
    end else if (clr) begin
      cnt_r <= 4'd0;
    end else if (inc && (cnt_r != LIMIT)) begin
      cnt_r <= cnt_r + 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign at_limit = (cnt_r == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Define MEM_PORT_ARB_RR_EN for round-robin contention instead of data priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            m_req,
  output logic            m_we,
  output logic [DW/8-1:0] m_be,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  input  logic [DW-1:0]   m_rdata
);

  localparam int BW = DW / 8;

  owner_e owner_r;
  logic   at_limit_s;
  logic   fetch_win_s;
  logic   i_gnt_s;
  logic   d_gnt_s;

`ifdef MEM_PORT_ARB_RR_EN
  logic rr_last_data_r;

  // Remember the last winner so contention alternates; reset favours fetch first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_data_r <= 1'b1;
    end else if (i_gnt_s) begin
      rr_last_data_r <= 1'b0;
    end else if (d_gnt_s) begin
      rr_last_data_r <= 1'b1;
    end else begin
      rr_last_data_r <= rr_last_data_r;
    end
  end

  assign fetch_win_s = at_limit_s || rr_last_data_r;
`else
  assign fetch_win_s = at_limit_s;
`endif

  mem_port_starve_cnt #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .inc     (i_req && !i_gnt_s),
    .clr     (i_gnt_s || !i_req),
    .at_limit(at_limit_s)
  );

  // Grant decision: lone requester wins, contention goes to the policy.
  always_comb begin
    i_gnt_s = 1'b0;
    d_gnt_s = 1'b0;
    if (i_req && d_req) begin
      if (fetch_win_s) begin
        i_gnt_s = 1'b1;
      end else begin
        d_gnt_s = 1'b1;
      end
    end else if (i_req) begin
      i_gnt_s = 1'b1;
    end else if (d_req) begin
      d_gnt_s = 1'b1;
    end else begin
      i_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
    end
  end

  assign i_gnt = i_gnt_s;
  assign d_gnt = d_gnt_s;

  // Memory strobe mirrors the granted request; idle port is fully zeroed.
  always_comb begin
    m_req   = 1'b0;
    m_we    = 1'b0;
    m_be    = {BW{1'b0}};
    m_addr  = {AW{1'b0}};
    m_wdata = {DW{1'b0}};
    if (i_gnt_s) begin
      m_req  = 1'b1;
      m_be   = {BW{1'b1}};
      m_addr = i_addr;
    end else if (d_gnt_s) begin
      m_req   = 1'b1;
      m_we    = d_we;
      m_be    = d_be;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end else begin
      m_req = 1'b0;
    end
  end

  // Track which requester owns the read data returning next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_r <= OWN_NONE;
    end else begin
      owner_r <= next_owner(i_gnt_s, d_gnt_s, d_we);
    end
  end

  // Steer returning read data to its owner only.
  always_comb begin
    i_rvalid = 1'b0;
    i_rdata  = {DW{1'b0}};
    d_rvalid = 1'b0;
    d_rdata  = {DW{1'b0}};
    case (owner_r)
      OWN_INSTR: begin
        i_rvalid = 1'b1;
        i_rdata  = m_rdata;
      end
      OWN_DATA: begin
        d_rvalid = 1'b1;
        d_rdata  = m_rdata;
      end
      default: begin
        i_rvalid = 1'b0;
        d_rvalid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (both arbitration builds).
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic exp_i;
    logic [3:0] exp_cnt;

    rst = 1'b1; i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
    m_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_i_gnt", i_gnt, 1'b0);
    chk("rst_d_gnt", d_gnt, 1'b0);
    chk("rst_m_req", m_req, 1'b0);
    chk("rst_i_rvalid", i_rvalid, 1'b0);
    chk("rst_d_rvalid", d_rvalid, 1'b0);
    chk("rst_cnt", dut.u_starve.cnt_r, 4'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Fetch only, three cycles
    i_req = 1'b1; i_addr = 32'h0000_0010;
    @(negedge clk);
    chk("f0_i_gnt", i_gnt, 1'b1);
    chk("f0_d_gnt", d_gnt, 1'b0);
    chk("f0_m_req", m_req, 1'b1);
    chk("f0_m_addr", m_addr, 32'h10);
    chk("f0_m_we", m_we, 1'b0);
    chk("f0_m_be", m_be, 4'hF);
    chk("f0_m_wdata", m_wdata, 32'h0);
    chk("f0_i_rvalid", i_rvalid, 1'b0);
    @(posedge clk); #1 m_rdata = 32'h1111_1111;
    @(negedge clk);
    chk("f1_i_gnt", i_gnt, 1'b1);
    chk("f1_i_rvalid", i_rvalid, 1'b1);
    chk("f1_i_rdata", i_rdata, 32'h1111_1111);
    chk("f1_d_rvalid", d_rvalid, 1'b0);
    chk("f1_d_rdata", d_rdata, 32'h0);
    @(posedge clk); #1 m_rdata = 32'h2222_2222;
    @(negedge clk);
    chk("f2_i_gnt", i_gnt, 1'b1);
    chk("f2_i_rdata", i_rdata, 32'h2222_2222);
    @(posedge clk); #1 i_req = 1'b0; m_rdata = 32'h3333_3333;
    @(negedge clk);
    chk("f3_i_rvalid", i_rvalid, 1'b1);
    chk("f3_i_rdata", i_rdata, 32'h3333_3333);
    chk("f3_i_gnt", i_gnt, 1'b0);
    chk("f3_m_req", m_req, 1'b0);
    chk("f3_m_addr", m_addr, 32'h0);
    chk("f3_m_be", m_be, 4'h0);
    @(posedge clk); #1 m_rdata = 32'h4444_4444;
    @(negedge clk);
    chk("f4_i_rvalid", i_rvalid, 1'b0);
    chk("f4_i_rdata", i_rdata, 32'h0);

    // Reset so both builds start contention from the same state
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;

    // Single contention: load vs fetch
    i_req = 1'b1; i_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h100;
    @(negedge clk);
`ifdef MEM_PORT_ARB_RR_EN
    chk("c0_i_gnt", i_gnt, 1'b1);
    chk("c0_d_gnt", d_gnt, 1'b0);
    chk("c0_m_addr", m_addr, 32'h20);
`else
    chk("c0_i_gnt", i_gnt, 1'b0);
    chk("c0_d_gnt", d_gnt, 1'b1);
    chk("c0_m_addr", m_addr, 32'h100);
`endif
    @(posedge clk); #1 i_req = 1'b0; d_req = 1'b0; m_rdata = 32'hCAFE_F00D;
    @(negedge clk);
`ifdef MEM_PORT_ARB_RR_EN
    chk("c1_i_rvalid", i_rvalid, 1'b1);
    chk("c1_d_rvalid", d_rvalid, 1'b0);
    chk("c1_i_rdata", i_rdata, 32'hCAFE_F00D);
`else
    chk("c1_d_rvalid", d_rvalid, 1'b1);
    chk("c1_d_rdata", d_rdata, 32'hCAFE_F00D);
    chk("c1_i_rvalid", i_rvalid, 1'b0);
    chk("c1_i_rdata", i_rdata, 32'h0);
`endif

    // Sustained contention from reset for six cycles
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
`ifdef MEM_PORT_ARB_RR_EN
      exp_i = (k % 2 == 0);
`else
      exp_i = (k == 4);
      exp_cnt = (k == 5) ? 4'd0 : 4'(k);
      chk($sformatf("s%0d_cnt", k), dut.u_starve.cnt_r, exp_cnt);
`endif
      chk($sformatf("s%0d_i_gnt", k), i_gnt, exp_i);
      chk($sformatf("s%0d_d_gnt", k), d_gnt, !exp_i);
      @(posedge clk); #1;
    end

    // Lone store
    i_req = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0100; d_addr = 32'h200; d_wdata = 32'h00AB_0000;
    @(negedge clk);
    chk("st_d_gnt", d_gnt, 1'b1);
    chk("st_m_req", m_req, 1'b1);
    chk("st_m_we", m_we, 1'b1);
    chk("st_m_be", m_be, 4'b0100);
    chk("st_m_addr", m_addr, 32'h200);
    chk("st_m_wdata", m_wdata, 32'h00AB_0000);
    @(posedge clk); #1 d_req = 1'b0; d_we = 1'b0; m_rdata = 32'h5555_5555;
    @(negedge clk);
    chk("st1_d_rvalid", d_rvalid, 1'b0);
    chk("st1_i_rvalid", i_rvalid, 1'b0);

    // Contention then reset: counter and pending response dropped
    @(posedge clk); #1 i_req = 1'b1; d_req = 1'b1; d_be = 4'hF;
    @(posedge clk); #1 rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("r0_cnt", dut.u_starve.cnt_r, 4'd0);
    chk("r0_d_rvalid", d_rvalid, 1'b0);
    chk("r0_i_rvalid", i_rvalid, 1'b0);
    @(posedge clk); #1 rst = 1'b0;

    // Fetch grant, then reset the next cycle
    i_req = 1'b1; i_addr = 32'h40;
    @(negedge clk);
    chk("r1_i_gnt", i_gnt, 1'b1);
    @(posedge clk); #1 rst = 1'b1; i_req = 1'b0; m_rdata = 32'h6666_6666;
    @(negedge clk);
    chk("r2_i_rvalid", i_rvalid, 1'b0);
    chk("r2_owner", dut.owner_r, 2'd0);
    chk("r2_cnt", dut.u_starve.cnt_r, 4'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("r3_i_rvalid", i_rvalid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
